// File: rtl/sha256_pkg.sv
// SHA-256 shared constants and bit-mixing functions used by the compression core.
package sha256_pkg;

  // a..h (and H0..H7) as eight 32-bit words, element 0 in the most significant slot.
  typedef logic [0:7][31:0] state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2
  } core_state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One combinational SHA-256 round: a..h plus K[t], W[t] in, updated a..h out.
module sha256_round_comb
  import sha256_pkg::*;
(
  input  state_t      st_in,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output state_t      st_out
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = st_in[7] + Sigma1(st_in[4]) + Ch(st_in[4], st_in[5], st_in[6]) + k + w;
  assign t2 = Sigma0(st_in[0]) + Maj(st_in[0], st_in[1], st_in[2]);

  assign st_out[0] = t1 + t2;
  assign st_out[1] = st_in[0];
  assign st_out[2] = st_in[1];
  assign st_out[3] = st_in[2];
  assign st_out[4] = st_in[3] + t1;
  assign st_out[5] = st_in[4];
  assign st_out[6] = st_in[5];
  assign st_out[7] = st_in[6];

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 single-block compression with UNROLL chained rounds per clock.
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] chain_in,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         valid_out,
  output logic [255:0] hash_out
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("sha256_compress_core: UNROLL must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] CNT_STEP = 6'(UNROLL);
  localparam logic [5:0] CNT_LAST = 6'(64 - UNROLL);

  core_state_t      state_p0;
  logic [5:0]       cnt_p0;
  state_t           work_p0;
  state_t           chain_p0;
  state_t           hash_p0;
  logic [0:15][31:0] win_p0;
  logic [0:15][31:0] win_nxt;
  state_t           work_nxt;

  // Round chain: rounds cnt..cnt+UNROLL-1 evaluated combinationally in one cycle.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    localparam logic [5:0] OFS = 6'(j);
    state_t st_in;
    state_t st_out;
    if (j == 0) begin : g_first
      assign st_in = work_p0;
    end else begin : g_next
      assign st_in = g_rnd[j-1].st_out;
    end
    sha256_round_comb u_round (
      .st_in  (st_in),
      .k      (K_TABLE[cnt_p0 + OFS]),
      .w      (win_p0[j]),
      .st_out (st_out)
    );
  end

  assign work_nxt = g_rnd[UNROLL-1].st_out;

  // Schedule expansion: new word j may depend on words produced earlier in this same cycle.
  for (genvar j = 0; j < UNROLL; j++) begin : g_sch
    logic [31:0] w2, w7, w15, w16, wn;
    if (j < 2) begin : g_w2_win
      assign w2 = win_p0[14+j];
    end else begin : g_w2_new
      assign w2 = g_sch[j-2].wn;
    end
    if (j < 7) begin : g_w7_win
      assign w7 = win_p0[9+j];
    end else begin : g_w7_new
      assign w7 = g_sch[j-7].wn;
    end
    if (j < 15) begin : g_w15_win
      assign w15 = win_p0[1+j];
    end else begin : g_w15_new
      assign w15 = g_sch[j-15].wn;
    end
    assign w16 = win_p0[j];
    assign wn  = sigma1(w2) + w7 + sigma0(w15) + w16;
  end

  for (genvar i = 0; i < 16; i++) begin : g_win
    if (i + UNROLL < 16) begin : g_shift
      assign win_nxt[i] = win_p0[i+UNROLL];
    end else begin : g_fill
      assign win_nxt[i] = g_sch[i+UNROLL-16].wn;
    end
  end

  // Single register stage: control, working state, schedule window and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0  <= S_IDLE;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      cnt_p0    <= '0;
      work_p0   <= '0;
      chain_p0  <= '0;
      win_p0    <= '0;
      hash_p0   <= '0;
    end else begin
      valid_out <= 1'b0;
      unique case (state_p0)
        S_IDLE: begin
          if (start) begin
            chain_p0 <= chain_in;
            work_p0  <= chain_in;
            win_p0   <= block_in;
            cnt_p0   <= '0;
            ready    <= 1'b0;
            state_p0 <= S_RUN;
          end
        end
        S_RUN: begin
          work_p0 <= work_nxt;
          win_p0  <= win_nxt;
          cnt_p0  <= cnt_p0 + CNT_STEP;
          if (cnt_p0 == CNT_LAST) begin
            state_p0 <= S_FINAL;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hash_p0[i] <= chain_p0[i] + work_p0[i];
          end
          valid_out <= 1'b1;
          ready     <= 1'b1;
          state_p0  <= S_IDLE;
        end
        default: begin
          ready    <= 1'b1;
          state_p0 <= S_IDLE;
        end
      endcase
    end
  end

  assign hash_out = hash_p0;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench: runs UNROLL=1 and UNROLL=4 instances side by side on known SHA-256 vectors.
module tb_sha256_compress_core;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] chain_in;
  logic [511:0] block_in;
  logic         ready1, valid1, ready4, valid4;
  logic [255:0] hash1, hash4;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO1  = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  always #5 clk = ~clk;

  sha256_compress_core #(.UNROLL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .chain_in(chain_in), .block_in(block_in),
    .ready(ready1), .valid_out(valid1), .hash_out(hash1));

  sha256_compress_core #(.UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .chain_in(chain_in), .block_in(block_in),
    .ready(ready4), .valid_out(valid4), .hash_out(hash4));

  // Issues one start pulse and observes both instances for 80 edges; inputs are scrambled after acceptance.
  task automatic run_block(input logic [255:0] ch, input logic [511:0] blk,
                           output int lat1, output int lat4,
                           output logic [255:0] h1, output logic [255:0] h4,
                           output int pulses1, output int pulses4);
    @(negedge clk);
    chain_in = ch;
    block_in = blk;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    chain_in = ~ch;
    block_in = ~blk;
    lat1 = -1; lat4 = -1; h1 = '0; h4 = '0; pulses1 = 0; pulses4 = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (valid1) begin
        pulses1++;
        if (lat1 < 0) begin lat1 = k; h1 = hash1; end
      end
      if (valid4) begin
        pulses4++;
        if (lat4 < 0) begin lat4 = k; h4 = hash4; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; chain_in = '0; block_in = '0;
    #3;
    total_cnt++; if (ready1 !== 1'b1) $display("FAIL reset_ready1 got %b want 1", ready1); else pass_cnt++;
    total_cnt++; if (valid1 !== 1'b0) $display("FAIL reset_valid1 got %b want 0", valid1); else pass_cnt++;
    total_cnt++; if (hash1 !== 256'h0) $display("FAIL reset_hash1 got %h want 0", hash1); else pass_cnt++;
    total_cnt++; if (ready4 !== 1'b1) $display("FAIL reset_ready4 got %b want 1", ready4); else pass_cnt++;
    total_cnt++; if (hash4 !== 256'h0) $display("FAIL reset_hash4 got %h want 0", hash4); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (ready1 !== 1'b1 || valid1 !== 1'b0) $display("FAIL idle_after_reset ready=%b valid=%b want 1/0", ready1, valid1); else pass_cnt++;
  endtask

  task automatic test_abc();
    int l1, l4, p1, p4;
    logic [255:0] h1, h4;
    run_block(IV, BLK_ABC, l1, l4, h1, h4, p1, p4);
    total_cnt++; if (l1 !== 65) $display("FAIL abc_latency_u1 got %0d want 65", l1); else pass_cnt++;
    total_cnt++; if (l4 !== 17) $display("FAIL abc_latency_u4 got %0d want 17", l4); else pass_cnt++;
    total_cnt++; if (h1 !== DIG_ABC) $display("FAIL abc_digest_u1 got %h want %h", h1, DIG_ABC); else pass_cnt++;
    total_cnt++; if (h4 !== DIG_ABC) $display("FAIL abc_digest_u4 got %h want %h", h4, DIG_ABC); else pass_cnt++;
    total_cnt++; if (p1 !== 1 || p4 !== 1) $display("FAIL abc_one_pulse got %0d/%0d want 1/1", p1, p4); else pass_cnt++;
    total_cnt++; if (hash1 !== DIG_ABC) $display("FAIL abc_hold_u1 got %h want %h", hash1, DIG_ABC); else pass_cnt++;
  endtask

  task automatic test_empty();
    int l1, l4, p1, p4;
    logic [255:0] h1, h4;
    run_block(IV, BLK_EMPTY, l1, l4, h1, h4, p1, p4);
    total_cnt++; if (h1 !== DIG_EMPTY) $display("FAIL empty_digest_u1 got %h want %h", h1, DIG_EMPTY); else pass_cnt++;
    total_cnt++; if (h4 !== DIG_EMPTY) $display("FAIL empty_digest_u4 got %h want %h", h4, DIG_EMPTY); else pass_cnt++;
    total_cnt++; if (l1 !== 65 || l4 !== 17) $display("FAIL empty_latency got %0d/%0d want 65/17", l1, l4); else pass_cnt++;
  endtask

  task automatic test_two_block();
    int l1, l4, p1, p4;
    logic [255:0] h1, h4, mid;
    run_block(IV, BLK_TWO1, l1, l4, h1, h4, p1, p4);
    total_cnt++; if (h1 !== DIG_TWO1) $display("FAIL two_mid_u1 got %h want %h", h1, DIG_TWO1); else pass_cnt++;
    total_cnt++; if (h4 !== DIG_TWO1) $display("FAIL two_mid_u4 got %h want %h", h4, DIG_TWO1); else pass_cnt++;
    mid = h1;
    run_block(mid, BLK_TWO2, l1, l4, h1, h4, p1, p4);
    total_cnt++; if (h1 !== DIG_TWO) $display("FAIL two_final_u1 got %h want %h", h1, DIG_TWO); else pass_cnt++;
    total_cnt++; if (h4 !== DIG_TWO) $display("FAIL two_final_u4 got %h want %h", h4, DIG_TWO); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int first1 = -1, second1 = -1, first4 = -1, second4 = -1;
    int n1 = 0, n4 = 0;
    int waited;
    logic [255:0] last4 = '0;
    @(negedge clk);
    chain_in = IV; block_in = BLK_ABC; start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk);
      #1;
      if (valid1) begin
        n1++;
        if (first1 < 0) first1 = c; else if (second1 < 0) second1 = c;
      end
      if (valid4) begin
        n4++; last4 = hash4;
        if (first4 < 0) first4 = c; else if (second4 < 0) second4 = c;
      end
    end
    @(negedge clk);
    start = 1'b0;
    total_cnt++; if (second1 - first1 !== 66) $display("FAIL b2b_period_u1 got %0d want 66", second1 - first1); else pass_cnt++;
    total_cnt++; if (second4 - first4 !== 18) $display("FAIL b2b_period_u4 got %0d want 18", second4 - first4); else pass_cnt++;
    total_cnt++; if (n1 !== 2 || n4 !== 8) $display("FAIL b2b_count got %0d/%0d want 2/8", n1, n4); else pass_cnt++;
    total_cnt++; if (last4 !== DIG_ABC) $display("FAIL b2b_digest_u4 got %h want %h", last4, DIG_ABC); else pass_cnt++;
    waited = 0;
    while (!(ready1 && ready4) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++; if (!(ready1 && ready4)) $display("FAIL b2b_drain_timeout ready=%b/%b want 1/1", ready1, ready4); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int l1, l4, p1, p4, stray;
    logic [255:0] h1, h4;
    @(negedge clk);
    chain_in = IV; block_in = BLK_EMPTY; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    total_cnt++; if (ready1 !== 1'b0) $display("FAIL busy_ready_u1 got %b want 0", ready1); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (ready1 !== 1'b1) $display("FAIL midreset_ready got %b want 1", ready1); else pass_cnt++;
    total_cnt++; if (hash1 !== 256'h0) $display("FAIL midreset_hash got %h want 0", hash1); else pass_cnt++;
    total_cnt++; if (hash4 !== 256'h0) $display("FAIL midreset_hash_u4 got %h want 0", hash4); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (valid1 || valid4) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL midreset_no_valid got %0d pulses want 0", stray); else pass_cnt++;
    run_block(IV, BLK_ABC, l1, l4, h1, h4, p1, p4);
    total_cnt++; if (h1 !== DIG_ABC) $display("FAIL after_reset_abc_u1 got %h want %h", h1, DIG_ABC); else pass_cnt++;
    total_cnt++; if (h4 !== DIG_ABC) $display("FAIL after_reset_abc_u4 got %h want %h", h4, DIG_ABC); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
